// File: rtl/tdm_demux4.sv
// Receive side of the 4-channel TDM link: steers each accepted word to its slot register,
// tracks frame alignment with a HUNT/LOCKED machine and flags sync violations.
module tdm_demux4 #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic             in_sync,
    output logic [WIDTH-1:0] ch0_data,
    output logic [WIDTH-1:0] ch1_data,
    output logic [WIDTH-1:0] ch2_data,
    output logic [WIDTH-1:0] ch3_data,
    output logic [3:0]       ch_valid,
    output logic             frame_valid,
    output logic             locked,
    output logic             sync_err
);

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned SLOT_W = 2;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [SLOT_W-1:0]   slot_q, slot_d;
    logic [WIDTH-1:0]    ch_q [NUM_CH];
    logic [WIDTH-1:0]    ch_d [NUM_CH];
    logic [NUM_CH-1:0]   ch_valid_q, ch_valid_d;
    logic                frame_valid_q, frame_valid_d;
    logic                sync_err_q, sync_err_d;
    logic                locked_q, locked_d;

    // Alignment tracking and slot steering
    always_comb begin
        state_d       = state_q;
        slot_d        = slot_q;
        ch_d          = ch_q;
        ch_valid_d    = '0;
        frame_valid_d = 1'b0;
        sync_err_d    = 1'b0;

        if (in_valid) begin
            unique case (state_q)
                HUNT: begin
                    if (in_sync) begin
                        ch_d[0]       = in_data;
                        ch_valid_d[0] = 1'b1;
                        slot_d        = SLOT_W'(1);
                        state_d       = LOCKED;
                    end
                end
                LOCKED: begin
                    if (in_sync) begin
                        // An early sync abandons the partial frame and restarts at slot 0
                        sync_err_d    = (slot_q != '0);
                        ch_d[0]       = in_data;
                        ch_valid_d[0] = 1'b1;
                        slot_d        = SLOT_W'(1);
                    end else if (slot_q == '0) begin
                        sync_err_d = 1'b1;
                        state_d    = HUNT;
                        slot_d     = '0;
                    end else begin
                        ch_d[slot_q]       = in_data;
                        ch_valid_d[slot_q] = 1'b1;
                        frame_valid_d      = (slot_q == SLOT_W'(3));
                        slot_d             = slot_q + SLOT_W'(1);
                    end
                end
                default: state_d = HUNT;
            endcase
        end

        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= HUNT;
            slot_q        <= '0;
            ch_valid_q    <= '0;
            frame_valid_q <= 1'b0;
            sync_err_q    <= 1'b0;
            locked_q      <= 1'b0;
            for (int i = 0; i < int'(NUM_CH); i++) begin
                ch_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            slot_q        <= slot_d;
            ch_valid_q    <= ch_valid_d;
            frame_valid_q <= frame_valid_d;
            sync_err_q    <= sync_err_d;
            locked_q      <= locked_d;
            ch_q          <= ch_d;
        end
    end

    assign ch0_data    = ch_q[0];
    assign ch1_data    = ch_q[1];
    assign ch2_data    = ch_q[2];
    assign ch3_data    = ch_q[3];
    assign ch_valid    = ch_valid_q;
    assign frame_valid = frame_valid_q;
    assign locked      = locked_q;
    assign sync_err    = sync_err_q;

endmodule

// File: tb/tb_tdm_demux4.sv
// Bench for tdm_demux4: directed test-plan sequences plus random traffic, checked
// every cycle against a frame-level reference model.
module tb_tdm_demux4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       in_sync = 1'b0;
    logic [7:0] ch0_data, ch1_data, ch2_data, ch3_data;
    logic [3:0] ch_valid;
    logic       frame_valid, locked, sync_err;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [7:0] m_ch [4];
    int         m_slot;
    bit         m_lock;
    logic [3:0] e_cv;
    bit         e_fv, e_se;

    tdm_demux4 #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_sync(in_sync),
        .ch0_data(ch0_data), .ch1_data(ch1_data), .ch2_data(ch2_data), .ch3_data(ch3_data),
        .ch_valid(ch_valid), .frame_valid(frame_valid), .locked(locked), .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Frame rules applied to one sampled input cycle
    task automatic model(input bit r, input bit v, input bit s, input logic [7:0] d);
        e_cv = '0; e_fv = 0; e_se = 0;
        if (r) begin
            for (int i = 0; i < 4; i++) m_ch[i] = '0;
            m_slot = 0; m_lock = 0;
        end else if (v) begin
            if (!m_lock) begin
                if (s) begin
                    m_ch[0] = d; e_cv = 4'b0001; m_slot = 1; m_lock = 1;
                end
            end else if (s) begin
                e_se = (m_slot != 0);
                m_ch[0] = d; e_cv = 4'b0001; m_slot = 1;
            end else if (m_slot == 0) begin
                e_se = 1; m_lock = 0;
            end else begin
                m_ch[m_slot] = d;
                e_cv = 4'(1 << m_slot);
                e_fv = (m_slot == 3);
                m_slot = (m_slot + 1) % 4;
            end
        end
    endtask

    task automatic step(input bit r, input bit v, input bit s, input logic [7:0] d);
        @(negedge clk);
        rst = r; in_valid = v; in_sync = s; in_data = d;
        @(posedge clk);
        model(r, v, s, d);
        #1;
        check("ch0", ch0_data, m_ch[0]);
        check("ch1", ch1_data, m_ch[1]);
        check("ch2", ch2_data, m_ch[2]);
        check("ch3", ch3_data, m_ch[3]);
        check("ch_valid", ch_valid, e_cv);
        check("frame_valid", frame_valid, e_fv);
        check("sync_err", sync_err, e_se);
        check("locked", locked, m_lock);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 8'h00);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) m_ch[i] = '0;
        m_slot = 0; m_lock = 0;

        // Reset state
        step(1, 0, 0, 8'h00);
        step(1, 1, 1, 8'h5A);
        check("rst_ch0", ch0_data, 8'h00);
        check("rst_locked", locked, 1'b0);

        // Back-to-back frame
        step(0, 1, 1, 8'h11);
        check("f1_cv0", ch_valid, 4'b0001);
        check("f1_lock", locked, 1'b1);
        step(0, 1, 0, 8'h22);
        step(0, 1, 0, 8'h33);
        step(0, 1, 0, 8'h44);
        check("f1_cv3", ch_valid, 4'b1000);
        check("f1_fv", frame_valid, 1'b1);
        check("f1_ch3", ch3_data, 8'h44);
        idle(1);

        // Non-sync words while hunting are discarded
        step(1, 0, 0, 8'h00);
        step(0, 1, 0, 8'hAA);
        step(0, 1, 0, 8'hBB);
        check("hunt_ch1", ch1_data, 8'h00);
        check("hunt_lock", locked, 1'b0);

        // Early sync
        step(0, 1, 1, 8'h01);
        step(0, 1, 0, 8'h02);
        step(0, 1, 1, 8'h05);
        check("early_err", sync_err, 1'b1);
        check("early_ch0", ch0_data, 8'h05);
        check("early_ch1", ch1_data, 8'h02);
        check("early_lock", locked, 1'b1);

        // Complete frame to reach slot 0, then missing sync
        step(0, 1, 0, 8'h06);
        step(0, 1, 0, 8'h07);
        step(0, 1, 0, 8'h08);
        step(0, 1, 0, 8'h77);
        check("miss_err", sync_err, 1'b1);
        check("miss_lock", locked, 1'b0);
        check("miss_ch0", ch0_data, 8'h05);
        step(0, 1, 1, 8'h10);
        check("relock_ch0", ch0_data, 8'h10);
        check("relock", locked, 1'b1);
        step(0, 1, 0, 8'h12);
        step(0, 1, 0, 8'h13);
        step(0, 1, 0, 8'h14);

        // Frame with idle gaps
        step(0, 1, 1, 8'hA1); idle(3);
        step(0, 1, 0, 8'hA2); idle(3);
        step(0, 1, 0, 8'hA3); idle(3);
        step(0, 1, 0, 8'hA4);
        check("gap_fv", frame_valid, 1'b1);
        check("gap_ch2", ch2_data, 8'hA3);

        // Reset mid-frame
        step(0, 1, 1, 8'hC1);
        step(0, 1, 0, 8'hC2);
        step(0, 1, 0, 8'hC3);
        step(1, 1, 0, 8'hC4);
        check("mrst_ch2", ch2_data, 8'h00);
        step(0, 1, 0, 8'hC5);
        check("mrst_cv", ch_valid, 4'b0000);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            bit r, v, s;
            r = ($urandom_range(0, 199) == 0);
            v = ($urandom_range(0, 3) != 0);
            s = (m_lock && m_slot == 0) ? ($urandom_range(0, 15) != 0)
                                        : ($urandom_range(0, 7) == 0);
            step(r, v, s, 8'($urandom_range(0, 255)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tdm_demux4.md
Name: tdm_demux4

Overview:
- Receive end of the 4-channel time-division link driven by the team's 4:1 multiplexer path.
- Accepts one word per valid cycle, tagged with a frame-sync marker on slot 0.
- Steers each word to one of four registered channel outputs and pulses per-channel and per-frame valid flags.
- Tracks frame alignment with a small lock state machine and flags sync errors.

Parameters:
- WIDTH, 8, data word width in bits for the input word and each channel output.

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  synchronous reset, active-high
- in_data  input  WIDTH  incoming TDM word
- in_valid  input  1  in_data/in_sync are valid this cycle
- in_sync  input  1  marks the current word as slot 0 of a frame; ignored when in_valid=0
- ch0_data  output  WIDTH  last word captured for slot 0
- ch1_data  output  WIDTH  last word captured for slot 1
- ch2_data  output  WIDTH  last word captured for slot 2
- ch3_data  output  WIDTH  last word captured for slot 3
- ch_valid  output  4  bit k pulses 1 cycle when chk_data is updated
- frame_valid  output  1  pulses 1 cycle when slot 3 completes a frame
- locked  output  1  1 while in LOCKED state
- sync_err  output  1  pulses 1 cycle on an alignment violation

Behaviour:
- Reset (rst=1 at a rising edge):
  - ch0..ch3_data=0, ch_valid=0, frame_valid=0, sync_err=0, locked=0.
  - State=HUNT, slot counter=0.
  - Reset overrides any concurrent input; a partial frame is abandoned.
- Single clock domain, fully registered outputs.
- Latency: a word sampled at edge N appears on chk_data with ch_valid[k]=1 after edge N, i.e. one cycle.
- chk_data holds its value until the next capture for slot k.
- ch_valid, frame_valid and sync_err are single-cycle pulses; each defaults to 0 in any cycle with no triggering event.
- in_valid=0: no state change, no pulses, slot counter holds. Gaps of any length inside a frame are legal.
- Slot counter: 2 bits, increments by 1 per accepted word, wraps 3->0.
- HUNT state:
  - in_valid=1, in_sync=0: word discarded; no pulses; stay HUNT.
  - in_valid=1, in_sync=1: capture into ch0 with ch_valid[0] pulse; slot=1; go LOCKED.
- LOCKED state, in_valid=1:
  - slot==0 and in_sync=1: capture into ch0; slot=1.
  - slot!=0 and in_sync=0: capture into ch[slot]; slot=slot+1.
  - slot==3 capture: also pulse frame_valid, in the same cycle as ch_valid[3]; slot wraps to 0.
  - slot!=0 and in_sync=1 (early sync): sync_err pulse; the partial frame is dropped (no frame_valid); the word is captured into ch0 with ch_valid[0] pulse; slot=1; stay LOCKED.
  - slot==0 and in_sync=0 (missing sync): sync_err pulse; word discarded; go HUNT; slot=0.
- At most one ch_valid bit is set in any cycle.
- locked goes 1 on the cycle after the first accepted sync word. It goes 0 on the cycle after a missing-sync event.

Test Plan:
- Reset, then four valid words 0x11(sync),0x22,0x33,0x44 back-to-back:
  - ch0..3=0x11,0x22,0x33,0x44.
  - ch_valid pulses 0001,0010,0100,1000 on consecutive cycles.
  - frame_valid=1 with the 1000 pulse; locked=1 from the second cycle.
- Words 0xAA,0xBB with in_sync=0 before any sync -> discarded; ch0..3 stay 0, ch_valid=0, locked=0.
- Locked; sync word 0x01, then 0x02, then early sync 0x05:
  - sync_err pulse; ch0=0x05; ch1 stays 0x02; no frame_valid; locked stays 1.
- Locked at slot 0; word 0x77 with in_sync=0:
  - sync_err pulse; ch0 unchanged; locked=0 next cycle.
  - A following sync word 0x10 relocks: ch0=0x10, locked=1.
- Frame 0xA1..0xA4 with 3 idle cycles (in_valid=0) between each word:
  - Same outputs as the back-to-back case; no pulses during idle cycles.
- rst=1 asserted after slot 2 of a frame:
  - All outputs 0, locked=0.
  - A subsequent non-sync word is discarded (HUNT).
